// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration counter width.
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Counter must hold the value 2*width, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift one dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff_lo;

  assign w_trial = {i_rem, i_bit};
  // The difference is always below the divisor, so its low WIDTH bits are exact.
  assign w_diff_lo = w_trial[WIDTH-1:0] - i_divisor;
  assign o_q_bit   = (w_trial >= {1'b0, i_divisor});
  assign o_rem     = o_q_bit ? w_diff_lo : w_trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, start/busy/done handshake.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output state_t             dbg_state
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(2 * WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_count;
  logic [2*WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic [WIDTH-1:0]     r_rem;
  logic [2*WIDTH-2:0]   r_quot;
  logic [2*WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]     r_remainder;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     w_rem_next;
  logic                 w_q_bit;
  logic                 w_accept;
  logic                 w_accept_zero;
  logic                 w_last;

  assign w_accept      = (r_state == S_IDLE) && start && (divisor != '0);
  assign w_accept_zero = (r_state == S_IDLE) && start && (divisor == '0);
  assign w_last        = (r_state == S_RUN) && (r_count == CNT_ONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[2*WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)           w_next_state = S_RUN;
        else if (w_accept_zero) w_next_state = S_DONE;
      end
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Working registers shift left each RUN cycle; results latch on the edge
  // that enters DONE so they are valid together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dvd   <= dividend;
        r_dvs   <= divisor;
        r_rem   <= '0;
        r_quot  <= '0;
        r_count <= CNT_INIT;
      end else if (r_state == S_RUN) begin
        r_dvd   <= {r_dvd[2*WIDTH-2:0], 1'b0};
        r_rem   <= w_rem_next;
        r_quot  <= {r_quot[2*WIDTH-3:0], w_q_bit};
        r_count <= r_count - CNT_ONE;
      end

      if (w_accept_zero) begin
        r_quotient  <= '1;
        r_remainder <= dividend[WIDTH-1:0];
        r_div_zero  <= 1'b1;
      end else if (w_last) begin
        r_quotient  <= {r_quot, w_q_bit};
        r_remainder <= w_rem_next;
        r_div_zero  <= 1'b0;
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider: reset, latency, results,
// divide-by-zero, ignored starts, mid-run reset and back-to-back operation.
module tb_seq_divider;
  import divider_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  state_t         dbg_state;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   exp_r[$];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // One full division; elat is the cycle (after the accept edge) in which done appears.
  task automatic run_div(input logic [2*W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int elat, input string nm);
    int  k;
    int  busy_cnt;
    bit  seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; busy_cnt = 0; seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    checks++;
    if (!seen || k !== elat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, k, seen, elat);
    end
    checks++;
    if (busy_cnt !== elat - 1) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", nm, busy_cnt, elat - 1);
    end
    checks++;
    if (quotient !== eq) begin
      errors++;
      $display("FAIL %s quotient: got %0d expected %0d", nm, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      errors++;
      $display("FAIL %s remainder: got %0d expected %0d", nm, remainder, er);
    end
    checks++;
    if (div_zero !== edz) begin
      errors++;
      $display("FAIL %s div_zero: got %0b expected %0b", nm, div_zero, edz);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: busy=%0b done=%0b dz=%0b expected 0 0 0", busy, done, div_zero);
    end
    checks++;
    if (quotient !== 16'd0 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL reset results: q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset state: got %0d expected %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_basic();
    run_div(16'd165,   8'd15,  16'd11,    8'd0,  1'b0, 17, "165/15");
    run_div(16'd225,   8'd15,  16'd15,    8'd0,  1'b0, 17, "225/15");
    run_div(16'd100,   8'd7,   16'd14,    8'd2,  1'b0, 17, "100/7");
    run_div(16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, 17, "65535/1");
    run_div(16'd50,    8'd255, 16'd0,     8'd50, 1'b0, 17, "50/255");
    run_div(16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, 17, "65535/255");
  endtask

  task automatic test_div_zero();
    run_div(16'd300, 8'd0, 16'hFFFF, 8'd44, 1'b1, 1, "300/0");
  endtask

  task automatic test_busy_ignore();
    int  k;
    bit  seen;
    bit  bad;
    @(negedge clk);
    dividend = 16'd143; divisor = 8'd11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 16'd10; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 4; seen = 0;
    while (!seen && k < 40) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checks++;
    if (!seen || k !== 17) begin
      errors++;
      $display("FAIL busy_ignore latency: got %0d (seen=%0d) expected 17", k, seen);
    end
    checks++;
    if (quotient !== 16'd13 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL busy_ignore result: q=%0d r=%0d expected 13 0", quotient, remainder);
    end
    // A start raised in the done cycle must also be dropped.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd13 || remainder !== 8'd0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold_after_done: busy=%0b done=%0b q=%0d r=%0d expected 0 0 13 0",
               busy, done, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    bit got_done;
    @(negedge clk);
    dividend = 16'd200; divisor = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state: state=%0d busy=%0b done=%0b expected 0 0 0", dbg_state, busy, done);
    end
    checks++;
    if (quotient !== 16'd0 || remainder !== 8'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid results: q=%0d r=%0d dz=%0b expected 0 0 0", quotient, remainder, div_zero);
    end
    got_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) got_done = 1;
    end
    checks++;
    if (got_done) begin
      errors++;
      $display("FAIL reset_mid aborted run: got activity expected none");
    end
    run_div(16'd48, 8'd6, 16'd8, 8'd0, 1'b0, 17, "48/6 after reset");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n_done;
    int first_done;
    logic [2*W-1:0] eq;
    logic [W-1:0]   er;
    exp_q.push_back(16'd100); exp_r.push_back(8'd0);
    exp_q.push_back(16'd15);  exp_r.push_back(8'd15);
    @(negedge clk);
    dividend = 16'd1000; divisor = 8'd10; start = 1'b1;
    cyc = 0; n_done = 0; first_done = 0;
    while (n_done < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (n_done == 1 && cyc == first_done + 6) begin
        checks++;
        if (quotient !== 16'd100) begin
          errors++;
          $display("FAIL b2b hold: q=%0d expected 100", quotient);
        end
      end
      if (done) begin
        n_done++;
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        checks++;
        if (quotient !== eq || remainder !== er) begin
          errors++;
          $display("FAIL b2b result %0d: q=%0d r=%0d expected %0d %0d", n_done, quotient, remainder, eq, er);
        end
        if (n_done == 1) begin
          first_done = cyc;
          dividend = 16'd255; divisor = 8'd16;
        end else begin
          start = 1'b0;
          checks++;
          if (cyc - first_done !== 18) begin
            errors++;
            $display("FAIL b2b gap: got %0d expected 18", cyc - first_done);
          end
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n_done !== 2) begin
      errors++;
      $display("FAIL b2b done count: got %0d expected 2", n_done);
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(0, 255));
      if (b == 8'd0)
        run_div(a, b, 16'hFFFF, a[W-1:0], 1'b1, 1, "rand0");
      else
        run_div(a, b, a / {8'd0, b}, 8'(a % {8'd0, b}), 1'b0, 17, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
